// File: rtl/asip_trace_buffer.sv
// Triggered capture of retired-instruction records into a circular buffer, drained FWFT over valid/ready.
// Write lands at the clk edge and is readable next cycle; rd_data is combinational from memory and rd_ptr.
module asip_trace_buffer #(
  parameter int DATA_WIDTH     = 24,
  parameter int REG_ADDR_WIDTH = 6,
  parameter int DEPTH          = 16,
  localparam int ADDR_WIDTH    = $clog2(DEPTH),
  localparam int REC_WIDTH     = 3*DATA_WIDTH + REG_ADDR_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ev_valid,
  input  logic [DATA_WIDTH-1:0]     ev_pc,
  input  logic [DATA_WIDTH-1:0]     ev_instr,
  input  logic [DATA_WIDTH-1:0]     ev_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] ev_wreg,
  input  logic                      ev_branch,
  input  logic                      arm,
  input  logic                      stop,
  input  logic                      clear,
  input  logic                      wrap_mode,
  input  logic                      trig_en,
  input  logic [DATA_WIDTH-1:0]     trig_pc,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [REC_WIDTH-1:0]      rd_data,
  output logic [ADDR_WIDTH:0]       count,
  output logic [15:0]               dropped,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_e;

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [15:0]             dropped_q, dropped_d;
  logic [REC_WIDTH-1:0]    mem_q [DEPTH];

  logic                    full;
  logic                    pop;
  logic                    trig_hit;
  logic                    want_wr;
  logic                    blocked;
  logic                    wr_en;
  logic                    overwrite;
  logic                    drop;
  logic [REC_WIDTH-1:0]    ev_rec;

  assign ev_rec   = {ev_pc, ev_instr, ev_wdata, ev_wreg, ev_branch};
  assign full     = (count_q == FULL_CNT);
  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid && rd_ready;
  assign trig_hit = ev_valid && (!trig_en || (ev_pc == trig_pc));

  // In ARMED a simultaneous stop ends the session before capture starts, so the trigger is not stored.
  assign want_wr   = ((state_q == S_ARMED) && trig_hit && !stop) ||
                     ((state_q == S_CAPTURE) && ev_valid);
  assign blocked   = full && !pop && !wrap_mode;
  assign wr_en     = want_wr && !blocked && !clear;
  assign overwrite = wr_en && full && !pop;
  // A record is lost either by being refused (no wrap) or by evicting the oldest (wrap).
  assign drop      = want_wr && full && !pop && !clear;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop || overwrite) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_en && !pop && !overwrite) begin
      count_d = count_q + 1'b1;
    end else if (pop && !wr_en) begin
      count_d = count_q - 1'b1;
    end
    if (drop && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
      case (state_q)
        S_IDLE: begin
          if (arm) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (stop) state_q <= S_DONE;
          else if (trig_hit) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // Also catches a capture that started on an already-full buffer without wrap.
          if (stop || (!wrap_mode && (count_d == FULL_CNT))) state_q <= S_DONE;
        end
        S_DONE: begin
          if (arm) state_q <= S_ARMED;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_q[wr_ptr_q] <= ev_rec;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign dropped = dropped_q;
  assign state   = state_q;

endmodule
